// File: rtl/fluxo_dados_param.sv
// Datapath for the sequence-memory game: memory, round/address counters, play register, timeouts, LED mux.
// Latency: counters and registers update on the clock edge; all status outputs and memory reads are combinational.
// Backpressure: none. The controlling FSM sequences every operation through its zera/conta/registra/grava strobes.
module fluxo_dados_param #(
  parameter int N_BOTOES   = 4,
  parameter int ADDR_W     = 4,
  parameter int MAX_RODADA = 15,
  parameter int T_JOGADA   = 5000,
  parameter int T_INICIAL  = 2000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         zeraR,
  input  logic                         registraR,
  input  logic                         zeraCR,
  input  logic                         contaCR,
  input  logic                         zeraCE,
  input  logic                         contaCE,
  input  logic                         zeraT,
  input  logic                         contaT,
  input  logic                         zeraTI,
  input  logic                         contaTI,
  input  logic                         grava,
  input  logic [N_BOTOES-1:0]          botoes,
  output logic                         jogada_correta,
  output logic                         enderecoIgualRodada,
  output logic                         fimCE,
  output logic                         fimCR,
  output logic                         jogada_feita,
  output logic                         jogada_valida,
  output logic                         timeout,
  output logic                         timeout_jogada_inicial,
  output logic [N_BOTOES-1:0]          leds,
  output logic [ADDR_W-1:0]            db_contagem,
  output logic [ADDR_W-1:0]            db_rodada,
  output logic [N_BOTOES-1:0]          db_jogada,
  output logic [N_BOTOES-1:0]          db_memoria,
  output logic                         db_tem_jogada,
  output logic [$clog2(T_JOGADA)-1:0]  db_timeout_q
);

  localparam int TJ_W  = $clog2(T_JOGADA);
  localparam int TI_W  = $clog2(T_INICIAL);
  localparam int DEPTH = 2 ** ADDR_W;

  // Terminal values, sized to their counters so every comparison is width-matched.
  localparam logic [ADDR_W-1:0] LP_MAX_RODADA = ADDR_W'(MAX_RODADA);
  localparam logic [ADDR_W-1:0] LP_ADDR_ONE   = ADDR_W'(1);
  localparam logic [TJ_W-1:0]   LP_TJ_LAST    = TJ_W'(T_JOGADA - 1);
  localparam logic [TJ_W-1:0]   LP_TJ_ONE     = TJ_W'(1);
  localparam logic [TI_W-1:0]   LP_TI_LAST    = TI_W'(T_INICIAL - 1);
  localparam logic [TI_W-1:0]   LP_TI_ONE     = TI_W'(1);

  logic [ADDR_W-1:0]   r_rodada;
  logic [ADDR_W-1:0]   r_endereco;
  logic [N_BOTOES-1:0] r_jogada;
  logic [TJ_W-1:0]     r_cnt_jogada;
  logic [TI_W-1:0]     r_cnt_inicial;
  logic                r_tem_jogada_ant;
  logic [N_BOTOES-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0]   w_mem_addr;
  logic [N_BOTOES-1:0] w_mem_dado;
  logic                w_tem_jogada;
  logic [N_BOTOES-1:0] w_botoes_menos_um;

  // While recording, the write slot is the current round; otherwise the replay address selects the entry.
  assign w_mem_addr   = grava ? r_rodada : r_endereco;
  assign w_mem_dado   = r_mem[w_mem_addr];
  assign w_tem_jogada = |botoes;

  // Round counter: clear wins over count, saturates at the last round instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rodada <= '0;
    end else if (zeraCR) begin
      r_rodada <= '0;
    end else if (contaCR && (r_rodada != LP_MAX_RODADA)) begin
      r_rodada <= r_rodada + LP_ADDR_ONE;
    end
  end

  // Address counter: same clear/count/saturate behaviour as the round counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_endereco <= '0;
    end else if (zeraCE) begin
      r_endereco <= '0;
    end else if (contaCE && (r_endereco != LP_MAX_RODADA)) begin
      r_endereco <= r_endereco + LP_ADDR_ONE;
    end
  end

  // Play register: captures the pressed buttons for comparison against the stored sequence.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_jogada <= '0;
    end else if (zeraR) begin
      r_jogada <= '0;
    end else if (registraR) begin
      r_jogada <= botoes;
    end
  end

  // Sequence memory write port; contents deliberately survive reset so a restarted game can be replayed.
  always_ff @(posedge clock) begin
    if (grava) begin
      r_mem[w_mem_addr] <= botoes;
    end
  end

  // Play timeout: counts 0..T_JOGADA-1 and wraps, holding while contaT is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt_jogada <= '0;
    end else if (zeraT) begin
      r_cnt_jogada <= '0;
    end else if (contaT) begin
      if (r_cnt_jogada == LP_TJ_LAST) begin
        r_cnt_jogada <= '0;
      end else begin
        r_cnt_jogada <= r_cnt_jogada + LP_TJ_ONE;
      end
    end
  end

  // Initial-display timeout: same wrap-around counter, sized for T_INICIAL.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt_inicial <= '0;
    end else if (zeraTI) begin
      r_cnt_inicial <= '0;
    end else if (contaTI) begin
      if (r_cnt_inicial == LP_TI_LAST) begin
        r_cnt_inicial <= '0;
      end else begin
        r_cnt_inicial <= r_cnt_inicial + LP_TI_ONE;
      end
    end
  end

  // Edge detector history: previous-cycle "any button pressed".
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tem_jogada_ant <= 1'b0;
    end else begin
      r_tem_jogada_ant <= w_tem_jogada;
    end
  end

  // A value with exactly one bit set is non-zero and loses that bit when decremented.
  assign w_botoes_menos_um = botoes - N_BOTOES'(1);

  // Status, LED mux and debug outputs; LEDs show the stored sequence during display, go dark while recording.
  always_comb begin
    jogada_correta         = (w_mem_dado == r_jogada);
    enderecoIgualRodada    = (r_endereco == r_rodada);
    fimCE                  = (r_endereco == LP_MAX_RODADA);
    fimCR                  = (r_rodada == LP_MAX_RODADA);
    jogada_feita           = w_tem_jogada & ~r_tem_jogada_ant;
    jogada_valida          = w_tem_jogada && ((botoes & w_botoes_menos_um) == '0);
    timeout                = (r_cnt_jogada == LP_TJ_LAST);
    timeout_jogada_inicial = (r_cnt_inicial == LP_TI_LAST);
    if (contaTI) begin
      leds = w_mem_dado;
    end else if (grava) begin
      leds = '0;
    end else begin
      leds = botoes;
    end
    db_contagem   = r_endereco;
    db_rodada     = r_rodada;
    db_jogada     = r_jogada;
    db_memoria    = w_mem_dado;
    db_tem_jogada = w_tem_jogada;
    db_timeout_q  = r_cnt_jogada;
  end

endmodule

// File: tb/tb_fluxo_dados_param.sv
// Directed bench for fluxo_dados_param with a short play timeout and a 4-cycle initial timeout.
// Inputs change 2 ns after a rising edge; outputs are sampled 1 ns after that, well away from the edge.
// Ends with a single summary line of check and error counts.
module tb_fluxo_dados_param;

  localparam int NB = 4;
  localparam int AW = 4;
  localparam int TJ = 8;
  localparam int TI = 4;

  logic clock = 1'b0;
  logic reset;
  logic zeraR, registraR, zeraCR, contaCR, zeraCE, contaCE;
  logic zeraT, contaT, zeraTI, contaTI, grava;
  logic [NB-1:0] botoes;
  logic jogada_correta, enderecoIgualRodada, fimCE, fimCR;
  logic jogada_feita, jogada_valida, timeout, timeout_jogada_inicial;
  logic [NB-1:0] leds, db_jogada, db_memoria;
  logic [AW-1:0] db_contagem, db_rodada;
  logic db_tem_jogada;
  logic [$clog2(TJ)-1:0] db_timeout_q;

  int n_checks = 0;
  int n_errors = 0;

  fluxo_dados_param #(
    .N_BOTOES(NB), .ADDR_W(AW), .MAX_RODADA(15), .T_JOGADA(TJ), .T_INICIAL(TI)
  ) dut (
    .clock(clock), .reset(reset),
    .zeraR(zeraR), .registraR(registraR),
    .zeraCR(zeraCR), .contaCR(contaCR),
    .zeraCE(zeraCE), .contaCE(contaCE),
    .zeraT(zeraT), .contaT(contaT),
    .zeraTI(zeraTI), .contaTI(contaTI),
    .grava(grava), .botoes(botoes),
    .jogada_correta(jogada_correta), .enderecoIgualRodada(enderecoIgualRodada),
    .fimCE(fimCE), .fimCR(fimCR),
    .jogada_feita(jogada_feita), .jogada_valida(jogada_valida),
    .timeout(timeout), .timeout_jogada_inicial(timeout_jogada_inicial),
    .leds(leds), .db_contagem(db_contagem), .db_rodada(db_rodada),
    .db_jogada(db_jogada), .db_memoria(db_memoria),
    .db_tem_jogada(db_tem_jogada), .db_timeout_q(db_timeout_q)
  );

  always #5 clock = ~clock;

  // Compare observed against expected; X/Z on the DUT side counts as a mismatch.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and move to the input-drive point.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Hard stop in case something stalls the run.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] seq [4];
    logic [NB-1:0] v;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;

    reset = 1'b1;
    {zeraR, registraR, zeraCR, contaCR, zeraCE, contaCE} = '0;
    {zeraT, contaT, zeraTI, contaTI, grava} = '0;
    botoes = '0;
    #22;
    chk("rst_rodada", 32'(db_rodada), 0);
    chk("rst_contagem", 32'(db_contagem), 0);
    chk("rst_jogada", 32'(db_jogada), 0);
    chk("rst_tq", 32'(db_timeout_q), 0);
    chk("rst_fimCR", 32'(fimCR), 0);
    reset = 1'b0;
    tick();

    // Record the sequence at rounds 0..3; the round stops on 3.
    for (int i = 0; i < 4; i++) begin
      grava = 1'b1;
      botoes = seq[i];
      contaCR = (i < 3);
      #1;
      chk("rec_leds_dark", 32'(leds), 0);
      tick();
    end
    grava = 1'b0; contaCR = 1'b0; botoes = '0;
    #1;
    chk("rec_rodada", 32'(db_rodada), 3);

    // Replay: load each value into the play register and compare with memory.
    for (int i = 0; i < 4; i++) begin
      botoes = seq[i];
      registraR = 1'b1;
      tick();
      registraR = 1'b0;
      botoes = '0;
      #1;
      chk("rep_jogada", 32'(db_jogada), 32'(seq[i]));
      chk("rep_memoria", 32'(db_memoria), 32'(seq[i]));
      chk("rep_correta", 32'(jogada_correta), 1);
      chk("rep_end_eq_rod", 32'(enderecoIgualRodada), (i == 3) ? 1 : 0);
      if (i < 3) begin
        contaCE = 1'b1;
        tick();
        contaCE = 1'b0;
      end
    end
    // Wrong press against the entry at address 3.
    botoes = 4'b0001; registraR = 1'b1;
    tick();
    registraR = 1'b0; botoes = '0;
    #1;
    chk("rep_wrong", 32'(jogada_correta), 0);

    // Asynchronous reset in the middle of a timeout count, with round 3.
    contaT = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    contaT = 1'b0;
    #1;
    chk("pre_rst_tq", 32'(db_timeout_q), 5);
    reset = 1'b1;
    #1;
    chk("arst_rodada", 32'(db_rodada), 0);
    chk("arst_contagem", 32'(db_contagem), 0);
    chk("arst_jogada", 32'(db_jogada), 0);
    chk("arst_tq", 32'(db_timeout_q), 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mem_kept", 32'(db_memoria), 32'(seq[i]));
      contaCE = 1'b1;
      tick();
      contaCE = 1'b0;
    end

    // Round counter saturation and clear-over-count priority.
    zeraCR = 1'b1; tick(); zeraCR = 1'b0;
    contaCR = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk("sat_rodada", 32'(db_rodada), (c < 15) ? c : 15);
      chk("sat_fimCR", 32'(fimCR), (c >= 15) ? 1 : 0);
    end
    zeraCR = 1'b1;
    tick();
    zeraCR = 1'b0; contaCR = 1'b0;
    #1;
    chk("zera_pri_rodada", 32'(db_rodada), 0);

    // Edge detector and single-press validation.
    botoes = '0;
    tick();
    botoes = 4'b0100;
    #1;
    chk("edge_pulse", 32'(jogada_feita), 1);
    chk("edge_valida", 32'(jogada_valida), 1);
    chk("edge_tem", 32'(db_tem_jogada), 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("edge_held", 32'(jogada_feita), 0);
    end
    botoes = 4'b0110;
    #1;
    chk("multi_valida", 32'(jogada_valida), 0);
    chk("multi_no_pulse", 32'(jogada_feita), 0);
    botoes = '0;
    #1;
    chk("zero_valida", 32'(jogada_valida), 0);
    tick();
    botoes = 4'b0110;
    #1;
    chk("multi_pulse", 32'(jogada_feita), 1);
    botoes = '0;

    // Play timeout wrap and synchronous clear.
    zeraT = 1'b1; tick(); zeraT = 1'b0;
    contaT = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("tj_count", 32'(db_timeout_q), c % TJ);
      chk("tj_timeout", 32'(timeout), ((c % TJ) == TJ - 1) ? 1 : 0);
    end
    for (int c = 0; c < 3; c++) tick();
    zeraT = 1'b1;
    tick();
    zeraT = 1'b0; contaT = 1'b0;
    #1;
    chk("tj_zera", 32'(db_timeout_q), 0);
    tick();
    chk("tj_hold", 32'(db_timeout_q), 0);

    // LED source selection.
    zeraCE = 1'b1; tick(); zeraCE = 1'b0;
    botoes = 4'b1010;
    contaTI = 1'b1;
    #1;
    chk("leds_mem", 32'(leds), 32'(seq[0]));
    contaTI = 1'b0; grava = 1'b1;
    #1;
    chk("leds_grava", 32'(leds), 0);
    grava = 1'b0;
    #1;
    chk("leds_botoes", 32'(leds), 32'(4'b1010));

    // Initial-display timeout reaches its last count after TI-1 edges.
    zeraTI = 1'b1; tick(); zeraTI = 1'b0;
    contaTI = 1'b1;
    for (int c = 1; c <= TI; c++) begin
      tick();
      chk("ti_timeout", 32'(timeout_jogada_inicial), (c == TI - 1) ? 1 : 0);
    end
    contaTI = 1'b0;
    v = 4'b0000;
    botoes = v;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
